// File: rtl/sub86_muldiv_pkg.sv
// Shared op codes and FSM state encodings for the sub86 multiply/divide unit.
package sub86_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_IMUL = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_IDIV = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_MULI = 3'd2;
    localparam logic [2:0] S_DIVI = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

endpackage

// File: rtl/sub86_muldiv_if.sv
// Request/response bundle between the sub86 decode stage and the mul/div unit.
interface sub86_muldiv_if #(parameter int unsigned W = 32);

    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] SRCA;
    logic [W-1:0] SRCB;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESLO;
    logic [W-1:0] RESHI;
    logic         ERR;

    modport master (
        output START, OP, SRCA, SRCB,
        input  BUSY, DONE, RESLO, RESHI, ERR
    );

    modport slave (
        input  START, OP, SRCA, SRCB,
        output BUSY, DONE, RESLO, RESHI, ERR
    );

endinterface

// File: rtl/sub86_muldiv_negw.sv
// Conditional two's-complement negate used for operand magnitudes and sign fix-up.
module sub86_negw #(parameter int unsigned W = 32) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + 1'b1) : din;

endmodule

// File: rtl/sub86_muldiv.sv
// Iterative shift-add multiplier and restoring divider for the sub86 core.
// Divide support is built only when SUB86_MULDIV_DIV_EN is defined.
module sub86_muldiv
    import sub86_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input logic            CLK,
    input logic            RSTN,
    sub86_muldiv_if.slave  bus
);

    logic [2:0]     state;
    logic [1:0]     op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic           neg_res;
    logic [W-1:0]   reslo;
    logic [W-1:0]   reshi;
    logic           err;

    logic           sa;
    logic           sb;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic [2*W-1:0] prod;

    assign sa = op_r[0] & a_r[W-1];
    assign sb = op_r[0] & b_r[W-1];

    sub86_negw #(.W(W))   u_nega (.neg(sa),      .din(a_r), .dout(a_abs));
    sub86_negw #(.W(W))   u_negb (.neg(sb),      .din(b_r), .dout(b_abs));
    sub86_negw #(.W(2*W)) u_negp (.neg(neg_res), .din(acc), .dout(prod));

`ifdef SUB86_MULDIV_DIV_EN
    localparam int unsigned CW = $clog2(W) + 1;

    logic [CW-1:0]  cnt;
    logic           neg_rem;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic [2*W-1:0] div_next;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    // acc holds {remainder, dividend/quotient}; quotient bits shift in from the right
    assign rem_sh   = acc[2*W-1:W-1];
    assign diff     = rem_sh - {1'b0, b_r};
    assign div_next = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                              : {diff[W-1:0],   acc[W-2:0], 1'b1};

    sub86_negw #(.W(W)) u_negq (.neg(neg_res), .din(acc[W-1:0]),   .dout(quo_fix));
    sub86_negw #(.W(W)) u_negr (.neg(neg_rem), .din(acc[2*W-1:W]), .dout(rem_fix));
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            mcand   <= '0;
            neg_res <= 1'b0;
            reslo   <= '0;
            reshi   <= '0;
            err     <= 1'b0;
`ifdef SUB86_MULDIV_DIV_EN
            cnt     <= '0;
            neg_rem <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        op_r  <= bus.OP;
                        a_r   <= bus.SRCA;
                        b_r   <= bus.SRCB;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res <= sa ^ sb;
                    b_r     <= b_abs;
                    mcand   <= {{W{1'b0}}, a_abs};
                    if (op_r[1]) begin
`ifdef SUB86_MULDIV_DIV_EN
                        neg_rem <= sa;
                        acc     <= {{W{1'b0}}, a_abs};
                        cnt     <= CW'(W);
                        if (b_r == '0) begin
                            err   <= 1'b1;
                            reslo <= '1;
                            reshi <= a_r;
                            state <= S_FIN;
                        end else begin
                            err   <= 1'b0;
                            state <= S_DIVI;
                        end
`else
                        err   <= 1'b1;
                        reslo <= '0;
                        reshi <= '0;
                        state <= S_FIN;
`endif
                    end else begin
                        acc   <= '0;
                        err   <= 1'b0;
                        state <= (b_r == '0) ? S_FIX : S_MULI;
                    end
                end
                S_MULI: begin
                    if (b_r[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    b_r   <= b_r >> 1;
                    if (b_r[W-1:1] == '0) begin
                        state <= S_FIX;
                    end
                end
`ifdef SUB86_MULDIV_DIV_EN
                S_DIVI: begin
                    acc <= div_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_FIX;
                    end
                end
`endif
                S_FIX: begin
`ifdef SUB86_MULDIV_DIV_EN
                    if (op_r[1]) begin
                        reslo <= quo_fix;
                        reshi <= rem_fix;
                    end else begin
                        {reshi, reslo} <= prod;
                    end
`else
                    {reshi, reslo} <= prod;
`endif
                    state <= S_FIN;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY  = (state != S_IDLE);
    assign bus.DONE  = (state == S_FIN);
    assign bus.RESLO = reslo;
    assign bus.RESHI = reshi;
    assign bus.ERR   = err;

endmodule

// File: tb/tb_sub86_muldiv.sv
// Self-checking bench for sub86_muldiv (W=32): directed table, random ops vs model, reset/ignored-START sequences.
module tb_sub86_muldiv;
    import sub86_pkg::*;

    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;

    sub86_muldiv_if #(.W(32)) bus ();

    sub86_muldiv #(.W(32)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain arithmetic on the operands, latency from the spec's timing rules.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic err, output int lat);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] mag;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lo  = '0;
        hi  = '0;
        err = 1'b0;
        if (!op[1]) begin
            if (op[0]) p = 64'(sa * sb);
            else       p = {32'b0, a} * {32'b0, b};
            {hi, lo} = p;
            mag = (op[0] && b[31]) ? -b : b;
            lat = 3 + $clog2({1'b0, mag} + 33'd1);
        end else begin
`ifdef SUB86_MULDIV_DIV_EN
            if (b == 0) begin
                err = 1'b1; lo = '1; hi = a; lat = 2;
            end else if (op[0]) begin
                lo = 32'(sa / sb); hi = 32'(sa % sb); lat = 35;
            end else begin
                lo = a / b; hi = a % b; lat = 35;
            end
`else
            err = 1'b1; lat = 2;
`endif
        end
    endtask

    // Starts one op from idle and waits (bounded) for DONE; returns the observed latency.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] lo, output logic [31:0] hi,
                          output logic err, output int lat);
        @(posedge clk); #1;
        bus.START = 1'b1; bus.OP = op; bus.SRCA = a; bus.SRCB = b;
        @(posedge clk); #1;
        bus.START = 1'b0;
        lat = -1; lo = '0; hi = '0; err = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (bus.DONE) begin
                lat = c; lo = bus.RESLO; hi = bus.RESHI; err = bus.ERR;
                chk("busy_at_done", 64'(bus.BUSY), 64'(1));
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_op(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] elo, input logic [31:0] ehi,
                            input logic eerr, input int elat);
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        int          lat;
        run_op(op, a, b, lo, hi, err, lat);
        chk({tag, "_lo"},  64'(lo),  64'(elo));
        chk({tag, "_hi"},  64'(hi),  64'(ehi));
        chk({tag, "_err"}, 64'(err), 64'(eerr));
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] elo;
        logic [31:0] ehi;
        logic        eerr;
        int          elat;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dones;
        int          c;

        n_pass = 0; n_total = 0;
        bus.START = 1'b0; bus.OP = '0; bus.SRCA = '0; bus.SRCB = '0;

        vecs[0] = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 35};
        vecs[1] = '{OP_IMUL, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 6};
        vecs[2] = '{OP_MUL,  32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 3};
        vecs[3] = '{OP_IMUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 4};
`ifdef SUB86_MULDIV_DIV_EN
        vecs[4] = '{OP_IDIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 35};
        vecs[5] = '{OP_DIV,  32'h0000000A, 32'h00000000, 32'hFFFFFFFF, 32'h0000000A, 1'b1, 2};
        vecs[6] = '{OP_IDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 35};
        vecs[7] = '{OP_DIV,  32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 35};
`else
        vecs[4] = '{OP_IDIV, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 1'b1, 2};
        vecs[5] = '{OP_DIV,  32'h0000000A, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 2};
        vecs[6] = '{OP_IDIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 2};
        vecs[7] = '{OP_DIV,  32'h00000064, 32'h00000007, 32'h00000000, 32'h00000000, 1'b1, 2};
`endif

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(bus.BUSY),  64'(0));
        chk("rst_done",  64'(bus.DONE),  64'(0));
        chk("rst_err",   64'(bus.ERR),   64'(0));
        chk("rst_reslo", 64'(bus.RESLO), 64'(0));
        chk("rst_reshi", 64'(bus.RESHI), 64'(0));
        rstn = 1'b1;

        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].lo, vecs[i].hi, vecs[i].err, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            if (i % 10 == 3) rb = '0;
            if (i % 10 == 7) rb = 32'hFFFFFFFF;
            model(rop, ra, rb, elo, ehi, eerr, elat);
            check_op($sformatf("rnd%0d", i), rop, ra, rb, elo, ehi, eerr, elat);
        end

        // START pulsed mid-operation must not disturb the running multiply.
        @(posedge clk); #1;
        bus.START = 1'b1; bus.OP = OP_MUL; bus.SRCA = 32'h00010003; bus.SRCB = 32'h00000100;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.START = 1'b1; bus.OP = OP_IDIV; bus.SRCA = 32'hDEADBEEF; bus.SRCB = 32'h00000003;
        @(posedge clk); #1;
        bus.START = 1'b0;
        c = 4;
        while (!bus.DONE && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ign_lat", 64'(c), 64'(12));
        chk("ign_lo",  64'(bus.RESLO), 64'(32'h01000300));
        chk("ign_hi",  64'(bus.RESHI), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("ign_idle", 64'(bus.BUSY), 64'(0));

        // Reset at T+10 of a long multiply, with a coinciding START that must be dropped.
        @(posedge clk); #1;
        bus.START = 1'b1; bus.OP = OP_MUL; bus.SRCA = 32'hFFFFFFFF; bus.SRCB = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0; bus.START = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy",  64'(bus.BUSY),  64'(0));
        chk("mrst_done",  64'(bus.DONE),  64'(0));
        chk("mrst_err",   64'(bus.ERR),   64'(0));
        chk("mrst_reslo", 64'(bus.RESLO), 64'(0));
        chk("mrst_reshi", 64'(bus.RESHI), 64'(0));
        rstn = 1'b1; bus.START = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.DONE) dones++;
        end
        chk("mrst_no_done", 64'(dones), 64'(0));
        chk("mrst_idle",    64'(bus.BUSY), 64'(0));

        check_op("post_rst", OP_IMUL, 32'h00000007, 32'hFFFFFFFE,
                 32'hFFFFFFF2, 32'hFFFFFFFF, 1'b0, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sub86_muldiv.md
# sub86_muldiv

Parametrised iterative multiply/divide co-processor for the sub86 core. It generalises the core's in-line shift-add `mul`/`sml` sequencing into a stand-alone unit with a configurable operand width. It adds a full double-width product, signed/unsigned selection, and restoring division with remainder. The core's decode hands it two operands and an op code, stalls on `BUSY`, and writes `RESLO`/`RESHI` back on `DONE`.

## Interface
- `W`, default 32: operand width; legal values are 8 to 64.
- `CLK` input, 1 bit: the single clock; all state changes on its rising edge.
- `RSTN` input, 1 bit: reset, synchronous and active-low.
- `START` input, 1 bit: request. Sampled only in IDLE.
- `OP` input, 2 bits: 00 MUL (unsigned), 01 IMUL (signed), 10 DIV (unsigned), 11 IDIV (signed).
- `SRCA` input, W bits: multiplicand or dividend. Captured with `START`.
- `SRCB` input, W bits: multiplier or divisor. Captured with `START`.
- `BUSY` output, 1 bit: high from the cycle after acceptance until `DONE`, inclusive.
- `DONE` output, 1 bit: one-cycle completion pulse.
- `RESLO` output, W bits: low half of the product, or the quotient.
- `RESHI` output, W bits: high half of the product, or the remainder.
- `ERR` output, 1 bit: divide by zero or unsupported op. Valid with `DONE`.

## Operation
- States: IDLE, PREP, MULI, DIVI, FIX, FIN.
- IDLE:
  - `START`=1 captures `OP`, `SRCA`, `SRCB` and moves to PREP.
  - `START`=0 stays in IDLE.
  - `START` outside IDLE is ignored.
- PREP:
  - Signed ops replace each operand by its magnitude and record the sign of the result.
  - MUL/IMUL go to MULI. If |B| is zero they go straight to FIX.
  - DIV/IDIV go to DIVI. If the divisor is zero they go to FIN with `ERR`=1, `RESLO`=all ones, `RESHI`=`SRCA`.
- MULI, one step per cycle:
  - If multiplier bit 0 is 1, the 2W accumulator += the 2W-wide shifted multiplicand.
  - Multiplicand shifts left by 1; multiplier shifts right by 1.
  - Exit to FIX when the shifted multiplier becomes zero (early termination).
- DIVI:
  - Restoring division, MSB first.
  - Exactly W cycles, counted by a log2(W)+1-bit counter. Then go to FIX.
- FIX:
  - IMUL negates the 2W product when the operand signs differ.
  - IDIV negates the quotient when the signs differ, and gives the remainder the sign of the dividend.
  - Unsigned ops pass through unchanged.
- FIN: `DONE`=1, `BUSY`=1, then return to IDLE.
- Results hold in `RESLO`/`RESHI` from FIN until the next accepted `START`.
- All arithmetic is modulo 2^W per half.
  - IDIV of most-negative / -1 gives quotient = most-negative, remainder = 0, `ERR`=0.

## Timing
- Reset (`RSTN`=0 at an edge):
  - Next cycle: state IDLE; `BUSY`, `DONE`, `ERR` = 0; `RESLO`, `RESHI` = 0.
  - This applies mid-operation as well. A `START` coinciding with reset is dropped.
- Let T be the cycle in which `START` is sampled in IDLE.
  - PREP occupies T+1. `DONE` is high in cycle T+3+n.
  - MUL/IMUL: n = index of the MSB of |B| plus 1, or 0 if B=0.
  - DIV/IDIV: n = W.
  - Divide by zero: `DONE` in T+2.
- A new `START` is accepted earliest in the cycle after FIN. There are no back-to-back overlaps.

## Configuration
- Macro `SUB86_MULDIV_DIV_EN`.
- Defined: DIV and IDIV are implemented as described above.
- Undefined:
  - The DIVI state and the divide datapath are not built.
  - `OP`[1]=1 goes PREP→FIN with `ERR`=1 and `RESLO`=`RESHI`=0, so `DONE` is in T+2.
  - MUL and IMUL are unchanged.

## Structure
- Shared package `sub86_pkg`: op-code constants (`OP_MUL`, `OP_IMUL`, `OP_DIV`, `OP_IDIV`) and state encodings.
- Sub-module `sub86_negw` (parameter W): conditional two's-complement negate, `out = neg ? ~in+1 : in`.
  - Instantiated for operand magnitudes in PREP and for sign fix-up in FIX (once at 2W for the product).

## Test plan
- MUL, W=32, A=B=0xFFFFFFFF → `RESHI`=0xFFFFFFFE, `RESLO`=0x00000001, `DONE` at T+35.
- IMUL, A=0xFFFFFFFD (-3), B=5 → `RESHI`=0xFFFFFFFF, `RESLO`=0xFFFFFFF1, `DONE` at T+6.
- MUL, A=0x1234, B=0 → `RESHI`=`RESLO`=0, `DONE` at T+3, `ERR`=0.
- IDIV, A=0xFFFFFFF9 (-7), B=2 → `RESLO`=0xFFFFFFFD, `RESHI`=0xFFFFFFFF, `DONE` at T+35.
- DIV, A=10, B=0 → `ERR`=1, `RESLO`=0xFFFFFFFF, `RESHI`=0x0000000A, `DONE` at T+2. With the macro undefined: `ERR`=1, results 0.
- Reset and ignored `START`:
  - `RSTN` low at T+10 of a MUL → IDLE next cycle, all outputs 0, no `DONE` pulse.
  - `START` pulsed while `BUSY` → ignored, first result unaffected.
